// File: rtl/alu_wb_buffer_if.sv
// Writeback buffer bus: ALU-side push, register-file-side drain,
// forwarding lookup and the trap-drop counter.
interface alu_wb_buffer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] in_waddr;
   logic [DATA_WIDTH-1:0] in_result;
   logic                  in_overflow;
   logic                  in_carryout;
   logic                  in_zero;
   logic                  in_trap_ov;

   logic                  out_valid;
   logic                  out_ready;
   logic                  out_wen;
   logic [ADDR_WIDTH-1:0] out_waddr;
   logic [DATA_WIDTH-1:0] out_wdata;
   logic                  out_exc;
   logic                  out_carryout;
   logic                  out_zero;

   logic [ADDR_WIDTH-1:0] fwd_raddr;
   logic                  fwd_hit;
   logic [DATA_WIDTH-1:0] fwd_data;

   logic [7:0]            ov_drop_cnt;

   // Environment side: ALU, register-file port and operand fetch.
   modport master (
      output in_valid, in_waddr, in_result, in_overflow, in_carryout, in_zero, in_trap_ov,
      output out_ready, fwd_raddr,
      input  in_ready, out_valid, out_wen, out_waddr, out_wdata, out_exc,
      input  out_carryout, out_zero, fwd_hit, fwd_data, ov_drop_cnt
   );

   // Buffer side.
   modport slave (
      input  in_valid, in_waddr, in_result, in_overflow, in_carryout, in_zero, in_trap_ov,
      input  out_ready, fwd_raddr,
      output in_ready, out_valid, out_wen, out_waddr, out_wdata, out_exc,
      output out_carryout, out_zero, fwd_hit, fwd_data, ov_drop_cnt
   );
endinterface

// File: rtl/alu_wb_buffer.sv
// In-order writeback buffer behind the ALU. Suppressed writes (overflow
// trap or r0 target) stay in the queue so drain order is preserved.
module alu_wb_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 4
) (
   input logic             clk,
   input logic             rst_n,
   alu_wb_buffer_if.slave  bus
);
   localparam int         PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [PW:0]           r_count;
   logic [7:0]            r_ov_cnt;

   logic                  r_wen   [DEPTH];
   logic                  r_exc   [DEPTH];
   logic [ADDR_WIDTH-1:0] r_waddr [DEPTH];
   logic [DATA_WIDTH-1:0] r_data  [DEPTH];
   logic                  r_cy    [DEPTH];
   logic                  r_zero  [DEPTH];

   logic                  w_push;
   logic                  w_pop;
   logic                  w_exc;
   logic                  w_wen;
   logic [PW-1:0]         w_fidx;
   logic                  w_fwd_hit;
   logic [DATA_WIDTH-1:0] w_fwd_data;

   assign bus.in_ready  = (r_count != FULL);
   assign bus.out_valid = (r_count != '0);
   assign w_push        = bus.in_valid & bus.in_ready;
   assign w_pop         = bus.out_valid & bus.out_ready;
   assign w_exc         = bus.in_overflow & bus.in_trap_ov;
   assign w_wen         = ~w_exc & (bus.in_waddr != '0);

   // Entry storage: write the incoming result at the tail on push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_wen[i]   <= 1'b0;
            r_exc[i]   <= 1'b0;
            r_waddr[i] <= '0;
            r_data[i]  <= '0;
            r_cy[i]    <= 1'b0;
            r_zero[i]  <= 1'b0;
         end
      end else if (w_push) begin
         r_wen[r_wr_ptr]   <= w_wen;
         r_exc[r_wr_ptr]   <= w_exc;
         r_waddr[r_wr_ptr] <= bus.in_waddr;
         r_data[r_wr_ptr]  <= bus.in_result;
         r_cy[r_wr_ptr]    <= bus.in_carryout;
         r_zero[r_wr_ptr]  <= bus.in_zero;
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end

   // Saturating count of writes suppressed by an overflow trap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                     r_ov_cnt <= '0;
      else if (w_push && w_exc && (r_ov_cnt != '1))  r_ov_cnt <= r_ov_cnt + 1'b1;
   end

   // Forwarding: scan oldest to youngest so the youngest match wins.
   always_comb begin
      w_fwd_hit  = 1'b0;
      w_fwd_data = '0;
      w_fidx     = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         w_fidx = r_rd_ptr + PW'(i);
         if (((PW+1)'(i) < r_count) && r_wen[w_fidx] && (bus.fwd_raddr != '0) &&
             (r_waddr[w_fidx] == bus.fwd_raddr)) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_data[w_fidx];
         end
      end
   end

   assign bus.out_wen      = r_wen[r_rd_ptr];
   assign bus.out_exc      = r_exc[r_rd_ptr];
   assign bus.out_waddr    = r_waddr[r_rd_ptr];
   assign bus.out_wdata    = r_data[r_rd_ptr];
   assign bus.out_carryout = r_cy[r_rd_ptr];
   assign bus.out_zero     = r_zero[r_rd_ptr];
   assign bus.fwd_hit      = w_fwd_hit;
   assign bus.fwd_data     = w_fwd_data;
   assign bus.ov_drop_cnt  = r_ov_cnt;
endmodule

// File: tb/tb_alu_wb_buffer.sv
// Scoreboard bench for alu_wb_buffer: accepted pushes are turned into
// expected entries by the writeback rules; a negedge monitor compares head,
// handshake, forwarding and drop-count outputs against that queue.
module tb_alu_wb_buffer;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_wb_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   alu_wb_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic          wen;
      logic          exc;
      logic [AW-1:0] waddr;
      logic [DW-1:0] data;
      logic          cy;
      logic          z;
   } ent_t;

   ent_t sb[$];
   int   exp_drops = 0;
   int   n_cmp     = 0;
   int   n_err     = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare visible state, then retire a pop and record a push.
   always @(negedge clk) begin
      logic          hit;
      logic [DW-1:0] fd;
      logic          can_push;
      ent_t          e;
      if (!rst_n) begin
         sb.delete();
         exp_drops = 0;
      end else begin
         chk("out_valid", bus.out_valid, sb.size() != 0);
         chk("in_ready", bus.in_ready, sb.size() != DEPTH);
         chk("ov_drop_cnt", bus.ov_drop_cnt, exp_drops);
         hit = 1'b0;
         fd  = '0;
         for (int i = 0; i < sb.size(); i++) begin
            if (bus.fwd_raddr != 0 && sb[i].wen && sb[i].waddr == bus.fwd_raddr) begin
               hit = 1'b1;
               fd  = sb[i].data;
            end
         end
         chk("fwd_hit", bus.fwd_hit, hit);
         chk("fwd_data", bus.fwd_data, fd);
         if (sb.size() != 0) begin
            chk("out_wen", bus.out_wen, sb[0].wen);
            chk("out_exc", bus.out_exc, sb[0].exc);
            chk("out_waddr", bus.out_waddr, sb[0].waddr);
            chk("out_wdata", bus.out_wdata, sb[0].data);
            chk("out_carryout", bus.out_carryout, sb[0].cy);
            chk("out_zero", bus.out_zero, sb[0].z);
         end
         can_push = (sb.size() != DEPTH);
         if (sb.size() != 0 && bus.out_ready) e = sb.pop_front();
         if (bus.in_valid && can_push) begin
            e.exc   = bus.in_overflow && bus.in_trap_ov;
            e.wen   = !e.exc && (bus.in_waddr != 0);
            e.waddr = bus.in_waddr;
            e.data  = bus.in_result;
            e.cy    = bus.in_carryout;
            e.z     = bus.in_zero;
            sb.push_back(e);
            if (e.exc && exp_drops < 255) exp_drops++;
         end
      end
   end

   task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic ov, input logic cy, input logic z, input logic tr,
                        input logic ordy, input logic [AW-1:0] ra);
      bus.in_valid    = v;
      bus.in_waddr    = a;
      bus.in_result   = d;
      bus.in_overflow = ov;
      bus.in_carryout = cy;
      bus.in_zero     = z;
      bus.in_trap_ov  = tr;
      bus.out_ready   = ordy;
      bus.fwd_raddr   = ra;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic ordy, input logic [AW-1:0] ra);
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, ordy, ra);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_in_ready"}, bus.in_ready, 1);
      chk({tag, "_out_wen"}, bus.out_wen, 0);
      chk({tag, "_out_waddr"}, bus.out_waddr, 0);
      chk({tag, "_out_wdata"}, bus.out_wdata, 0);
      chk({tag, "_out_exc"}, bus.out_exc, 0);
      chk({tag, "_out_cy"}, bus.out_carryout, 0);
      chk({tag, "_out_zero"}, bus.out_zero, 0);
      chk({tag, "_fwd_hit"}, bus.fwd_hit, 0);
      chk({tag, "_fwd_data"}, bus.fwd_data, 0);
      chk({tag, "_ov_cnt"}, bus.ov_drop_cnt, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1'b1, '0);
      chk("drain_empty", bus.out_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0; bus.in_waddr = '0; bus.in_result = '0;
      bus.in_overflow = 1'b0; bus.in_carryout = 1'b0; bus.in_zero = 1'b0;
      bus.in_trap_ov = 1'b0; bus.out_ready = 1'b0; bus.fwd_raddr = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      rst_n = 1'b1;
      idle(1'b0, '0);

      // First entry: visible one edge after the push.
      drive(1'b1, 5'd3, 32'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3);
      idle(1'b0, 5'd3);
      idle(1'b1, '0);
      idle(1'b0, '0);

      // Fill to DEPTH, fifth offer rejected, then in-order drain.
      for (int i = 1; i <= 4; i++)
         drive(1'b1, AW'(i), 32'd100 + 32'(i), 1'b0, i[0], i[1], 1'b0, 1'b0, AW'(i));
      drive(1'b1, 5'd5, 32'd105, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4);
      drain();

      // Overflow trap, non-trapping overflow, r0 target.
      drive(1'b1, 5'd5, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5);
      drive(1'b1, 5'd5, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5);
      drive(1'b1, 5'd0, 32'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      drain();

      // Forwarding: youngest of two same-register entries, r0 lookup, after pop.
      drive(1'b1, 5'd8, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8);
      drive(1'b1, 5'd8, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8);
      idle(1'b0, 5'd8);
      idle(1'b0, 5'd0);
      idle(1'b1, 5'd8);
      idle(1'b1, 5'd8);
      idle(1'b0, 5'd8);

      // Steady push+pop at occupancy 2 across pointer wrap.
      drive(1'b1, 5'd9, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9);
      drive(1'b1, 5'd10, 32'h201, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10);
      for (int i = 0; i < 10; i++)
         drive(1'b1, AW'(11 + i), 32'h300 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, AW'(11 + i));
      drain();

      // Random traffic; small register range so forwarding hits happen.
      repeat (300) begin
         drive(1'($urandom), AW'($urandom_range(0, 7)), $urandom, 1'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               AW'($urandom_range(0, 7)));
      end
      drain();

      // Drop-counter saturation.
      repeat (300) begin
         drive(1'b1, AW'($urandom_range(1, 31)), $urandom, 1'b1, 1'b0, 1'b0, 1'b1,
               1'b1, AW'($urandom_range(0, 31)));
      end
      idle(1'b1, '0);
      chk("ov_drop_saturated", bus.ov_drop_cnt, 255);
      drain();

      // Reset in the middle of a drain.
      for (int i = 0; i < 3; i++)
         drive(1'b1, AW'(20 + i), 32'h400 + 32'(i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd21);
      idle(1'b1, 5'd21);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(posedge clk);
      #1;
      check_reset_outputs("midrst_hold");
      rst_n = 1'b1;
      idle(1'b1, 5'd21);
      idle(1'b0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/alu_wb_buffer.md
# alu_wb_buffer

Writeback buffer directly downstream of the 32-bit ALU. Captures each ALU result with its destination register number and flags, holds up to DEPTH entries in order, and drains them to the register-file write port under a valid/ready handshake. Provides a youngest-match forwarding lookup so operand fetch can bypass results not yet written back. Suppresses writes that would raise a signed-overflow trap or target register 0, and counts trap-suppressed writes.

## Interface
- DATA_WIDTH, 32, width of result/data
- ADDR_WIDTH, 5, register-number width
- DEPTH, 4, entry count; power of two, ≥2
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  ALU result presented
- in_ready  output  1  buffer can accept this cycle
- in_waddr  input  ADDR_WIDTH  destination register
- in_result  input  DATA_WIDTH  ALU Result
- in_overflow  input  1  ALU Overflow
- in_carryout  input  1  ALU CarryOut
- in_zero  input  1  ALU Zero
- in_trap_ov  input  1  op traps on signed overflow (add/sub, not addu/subu)
- out_valid  output  1  head entry present
- out_ready  input  1  write port accepts head
- out_wen  output  1  head entry's write-enable flag
- out_waddr  output  ADDR_WIDTH  head destination
- out_wdata  output  DATA_WIDTH  head data
- out_exc  output  1  head raised overflow trap
- out_carryout, out_zero  output  1 each  head flags
- fwd_raddr  input  ADDR_WIDTH  lookup register
- fwd_hit  output  1  lookup matched
- fwd_data  output  DATA_WIDTH  matched data
- ov_drop_cnt  output  8  trap-suppressed write count

## Operation
- Circular buffer: wr_ptr, rd_ptr (log2 DEPTH bits, wrap at DEPTH-1 → 0), count 0..DEPTH.
- Push = in_valid & in_ready; pop = out_valid & out_ready; both may occur in one cycle (count unchanged, both pointers advance).
- in_ready = (count != DEPTH); no combinational path from out_ready. Full buffer rejects push even when popping that cycle.
- On push: exc = in_overflow & in_trap_ov; wen = ~exc & (in_waddr != 0); store {wen, exc, in_waddr, in_result, in_carryout, in_zero}. Suppressed entries are still enqueued to preserve order.
- out_valid = (count != 0). out_* fields driven from entry at rd_ptr regardless of out_valid. Downstream writes the register file only when out_valid & out_ready & out_wen.
- ov_drop_cnt increments by 1 on each push with exc=1; saturates at 255.
- Forwarding (combinational): candidate = valid entry with wen=1 and waddr==fwd_raddr; fwd_raddr==0 never hits. fwd_data from youngest candidate (nearest behind wr_ptr); fwd_data=0 when fwd_hit=0. Entry popping this cycle still participates; entry being pushed this cycle does not.
- Mid-operation reset: all entries discarded, no drain.

## Timing
- Reset values: count 0, pointers 0, all storage 0, ov_drop_cnt 0; hence out_valid 0, out_wen 0, out_waddr 0, out_wdata 0, out_exc 0, out_carryout 0, out_zero 0, fwd_hit 0, fwd_data 0, in_ready 1.
- Latency: entry pushed at edge N is visible on out_* and fwd_* after edge N; no same-cycle flow-through when empty.
- Throughput: one push and one pop per cycle sustained when neither empty nor full.
- Head fields held stable while out_valid=1 and out_ready=0.

## Test plan
- Reset then idle: out_valid=0, in_ready=1, all outputs 0; push {waddr=3, result=0x0000_0007} → next cycle out_valid=1, out_wen=1, out_waddr=3, out_wdata=7.
- Fill with out_ready=0: 4 pushes (waddr 1..4) → in_ready=0 after 4th; 5th in_valid ignored; raise out_ready → drains 1,2,3,4 in order, one per cycle; in_ready=1 after first pop.
- Overflow trap: push result=0x8000_0000, overflow=1, trap_ov=1, waddr=5 → out_exc=1, out_wen=0, ov_drop_cnt=1; same with trap_ov=0 → out_wen=1, out_exc=0, count unchanged; waddr=0 push → out_wen=0.
- Forwarding: push waddr=8 data 0x11, then waddr=8 data 0x22, out_ready=0; fwd_raddr=8 → fwd_hit=1, fwd_data=0x22; fwd_raddr=0 → fwd_hit=0; pop both → fwd_hit=0.
- Simultaneous push/pop at count=2 for 10 cycles with pointer wrap → count stays 2, order preserved, no loss/duplication.
- Saturation and reset: 300 trap pushes (with draining) → ov_drop_cnt=255; assert rst_n low mid-drain → all outputs 0 immediately, in_ready=1.
